// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw asynchronous input into a clean debounced level
// plus single-cycle rise/fall pulses. An N-stage synchroniser feeds a
// counter-qualified FSM that accepts a new level only after COUNT_MAX
// consecutive agreeing samples.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   S_LOW      | settled low, dout=0
//   S_WAIT_HI  | s=1 seen, counting toward acceptance of high, dout=0
//   S_HIGH     | settled high, dout=1
//   S_WAIT_LO  | s=0 seen, counting toward acceptance of low, dout=1
module debounce_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_MAX   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic clear_b,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(COUNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Encoding chosen so dout is bit 1 and busy is bit 0: both outputs come
    // straight from a flop with no decode logic, so they cannot glitch.
    typedef enum logic [1:0] {
        S_LOW     = 2'b00,
        S_WAIT_HI = 2'b01,
        S_HIGH    = 2'b10,
        S_WAIT_LO = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Synchroniser chain; the clear does not touch it so the true input
    // level is always available for re-qualification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // FSM state, qualification counter and registered edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic; the synchronous clear dominates any acceptance.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!clear_b) begin
            state_d = S_LOW;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_LOW: begin
                    if (s) begin
                        state_d = S_WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_WAIT_HI: begin
                    if (!s) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!s) begin
                        state_d = S_WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_WAIT_LO: begin
                    if (s) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs taken directly from state and pulse flops.
    always_comb begin
        dout = state_q[1];
        busy = state_q[0];
        rise = rise_q;
        fall = fall_q;
    end

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync with COUNT_MAX=4, SYNC_STAGES=2.
// The reference model states the behaviour as "dout flips once s has differed
// from dout for COUNT_MAX consecutive edges", with s being din delayed by
// SYNC_STAGES edges.
module tb_debounce_sync;

    localparam int SYNC_STAGES = 2;
    localparam int COUNT_MAX   = 4;
    localparam int LAT         = SYNC_STAGES + COUNT_MAX;

    logic clk;
    logic reset;
    logic din;
    logic clear_b;
    logic dout, rise, fall, busy;

    int checks   = 0;
    int failures = 0;

    debounce_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .COUNT_MAX  (COUNT_MAX)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .clear_b(clear_b),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit m_dout, m_rise, m_fall;
    int m_run;
    bit m_hist[$];
    bit m_s;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dout = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            m_run  = 0;
            m_hist.delete();
        end else begin
            m_s = (m_hist.size() >= SYNC_STAGES) ? m_hist[SYNC_STAGES-1] : 1'b0;
            m_hist.push_front(din);
            if (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_back());
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (!clear_b) begin
                m_dout = 1'b0;
                m_run  = 0;
            end else if (m_s != m_dout) begin
                m_run++;
                if (m_run == COUNT_MAX) begin
                    m_dout = ~m_dout;
                    m_rise = m_dout;
                    m_fall = ~m_dout;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    function automatic logic [3:0] model_vec();
        return {m_dout, m_rise, m_fall, (m_run != 0)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic din_val);
        din     = din_val;
        clear_b = 1'b1;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();
    endtask

    task automatic test_reset();
        din     = 1'b1;
        clear_b = 1'b1;
        reset   = 1'b0;
        for (int i = 0; i < LAT + 3; i++) step();
        checks++;
        if (dout !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_high dout=%b expected=1", dout);
        end
        // Assert reset between edges and look before the next edge.
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_async outs=%b expected=0000", {dout, rise, fall, busy});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({dout, rise, fall, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_held cyc=%0d outs=%b expected=0000", i, {dout, rise, fall, busy});
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            checks++;
            if (dout !== (k >= LAT) || rise !== (k == LAT) || fall !== 1'b0) begin
                failures++;
                $display("FAIL reset_release edge=%0d dout=%b rise=%b fall=%b expected dout=%b rise=%b fall=0",
                         k, dout, rise, fall, (k >= LAT), (k == LAT));
            end
        end
    endtask

    task automatic test_clean_step();
        apply_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            checks++;
            if (busy !== (k > SYNC_STAGES && k < LAT) || dout !== (k >= LAT) || rise !== (k == LAT)) begin
                failures++;
                $display("FAIL clean_rise edge=%0d busy=%b dout=%b rise=%b expected busy=%b dout=%b rise=%b",
                         k, busy, dout, rise, (k > SYNC_STAGES && k < LAT), (k >= LAT), (k == LAT));
            end
            checks++;
            if ({dout, rise, fall, busy} !== model_vec()) begin
                failures++;
                $display("FAIL clean_rise_model edge=%0d outs=%b expected=%b", k, {dout, rise, fall, busy}, model_vec());
            end
        end
        din = 1'b0;
        for (int k = 1; k <= LAT + 2; k++) begin
            step();
            checks++;
            if (dout !== (k < LAT) || fall !== (k == LAT) || rise !== 1'b0) begin
                failures++;
                $display("FAIL clean_fall edge=%0d dout=%b fall=%b rise=%b expected dout=%b fall=%b rise=0",
                         k, dout, fall, rise, (k < LAT), (k == LAT));
            end
        end
    endtask

    task automatic test_bounce();
        int rises;
        apply_reset(1'b0);
        din = 1'b1;
        for (int i = 0; i < COUNT_MAX - 1; i++) step();
        din = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step();
            checks++;
            if (dout !== 1'b0 || rise !== 1'b0 || {dout, rise, fall, busy} !== model_vec()) begin
                failures++;
                $display("FAIL bounce_reject cyc=%0d outs=%b expected=%b (dout must stay 0)",
                         i, {dout, rise, fall, busy}, model_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bounce_busy busy=%b expected=0", busy);
        end
        rises = 0;
        din = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (rise === 1'b1) rises++;
        end
        checks++;
        if (rises != 1 || dout !== 1'b1) begin
            failures++;
            $display("FAIL bounce_accept rises=%0d dout=%b expected rises=1 dout=1", rises, dout);
        end
    endtask

    task automatic test_sync_clear();
        apply_reset(1'b1);
        checks++;
        if (dout !== 1'b1) begin
            failures++;
            $display("FAIL clear_pre dout=%b expected=1", dout);
        end
        clear_b = 1'b0;
        step();
        clear_b = 1'b1;
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_apply outs=%b expected=0000", {dout, rise, fall, busy});
        end
        for (int k = 1; k <= COUNT_MAX + 1; k++) begin
            step();
            checks++;
            if (dout !== (k >= COUNT_MAX) || rise !== (k == COUNT_MAX) || fall !== 1'b0) begin
                failures++;
                $display("FAIL clear_requal edge=%0d dout=%b rise=%b fall=%b expected dout=%b rise=%b fall=0",
                         k, dout, rise, fall, (k >= COUNT_MAX), (k == COUNT_MAX));
            end
        end
    endtask

    task automatic test_clear_wins();
        apply_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k < LAT; k++) step();
        checks++;
        if (busy !== 1'b1 || dout !== 1'b0) begin
            failures++;
            $display("FAIL clearwin_pre busy=%b dout=%b expected busy=1 dout=0", busy, dout);
        end
        clear_b = 1'b0;
        step();
        clear_b = 1'b1;
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000 || {dout, rise, fall, busy} !== model_vec()) begin
            failures++;
            $display("FAIL clearwin_edge outs=%b expected=0000", {dout, rise, fall, busy});
        end
        for (int k = 1; k <= COUNT_MAX; k++) step();
        checks++;
        if (dout !== 1'b1 || rise !== 1'b1) begin
            failures++;
            $display("FAIL clearwin_requal dout=%b rise=%b expected dout=1 rise=1", dout, rise);
        end
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        apply_reset(1'b0);
        din = 1'b1;
        for (int k = 1; k <= SYNC_STAGES + 2; k++) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midwait_pre busy=%b expected=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || dout !== 1'b0) begin
            failures++;
            $display("FAIL midwait_async busy=%b dout=%b expected 0 0", busy, dout);
        end
        din = 1'b0;
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3 * LAT; i++) begin
            step();
            if (rise === 1'b1 || fall === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL midwait_nopulse events=%0d expected=0", pulses);
        end
    endtask

    task automatic test_toggle();
        int changes;
        apply_reset(1'b0);
        changes = 0;
        for (int i = 0; i < 60; i++) begin
            din = ~din;
            step();
            if (dout !== 1'b0 || rise !== 1'b0 || fall !== 1'b0) changes++;
        end
        checks++;
        if (changes != 0) begin
            failures++;
            $display("FAIL toggle_stable bad_cycles=%0d expected=0", changes);
        end
    endtask

    task automatic test_random();
        int bad;
        int both;
        apply_reset(1'b0);
        bad  = 0;
        both = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) din = ~din;
            clear_b = ($urandom_range(0, 49) != 0);
            step();
            if ({dout, rise, fall, busy} !== model_vec()) begin
                bad++;
                if (bad <= 5)
                    $display("FAIL random_model cyc=%0d outs=%b expected=%b", i, {dout, rise, fall, busy}, model_vec());
            end
            if (rise === 1'b1 && fall === 1'b1) both++;
        end
        clear_b = 1'b1;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL random_model_total mismatching_cycles=%0d expected=0", bad);
        end
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL random_exclusive both_high_cycles=%0d expected=0", both);
        end
    endtask

    initial begin
        reset   = 1'b1;
        din     = 1'b0;
        clear_b = 1'b1;
        step();
        checks++;
        if ({dout, rise, fall, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL initial_reset outs=%b expected=0000", {dout, rise, fall, busy});
        end
        test_reset();
        test_clean_step();
        test_bounce();
        test_sync_clear();
        test_clear_wins();
        test_reset_mid_wait();
        test_toggle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw asynchronous input (push-button, switch, external strobe) into a clean, glitch-free level plus single-cycle edge pulses.
- Sits directly upstream of the register stages: dout drives a flop d input; rise/fall drive enables or sync clears.
- Comprises an N-stage synchroniser, then a counter-based debounce FSM with a synchronous active-low clear.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2
COUNT_MAX, 16, consecutive synchronised samples needed to accept a new level; legal range >= 2
CNT_W, $clog2(COUNT_MAX+1), counter width; derived localparam, not overridable

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
din  input  1  raw asynchronous input, may bounce
clear_b  input  1  synchronous active-low clear of debounce state
dout  output  1  debounced level, registered
rise  output  1  one-cycle pulse when dout goes 0->1, registered
fall  output  1  one-cycle pulse when dout goes 1->0, registered
busy  output  1  high while a candidate level change is being qualified

Behaviour:
- Reset is asynchronous and active-high. Asserting reset immediately clears all synchroniser flops, the counter and all outputs to 0, and sets state to S_LOW. Reset has priority over everything.
- Synchroniser: din shifts through SYNC_STAGES flops every edge. s is the last stage. clear_b does not affect the chain.
- FSM states:
  - S_LOW: dout=0.
  - S_WAIT_HI: dout=0, busy=1.
  - S_HIGH: dout=1.
  - S_WAIT_LO: dout=1, busy=1.
- Transitions, evaluated at each rising edge with reset low and clear_b high:
  - S_LOW and s=1: go to S_WAIT_HI, cnt<=1.
  - S_WAIT_HI and s=0: go to S_LOW, cnt<=0. This is a bounce; no pulse.
  - S_WAIT_HI, s=1 and cnt<COUNT_MAX-1: cnt<=cnt+1.
  - S_WAIT_HI, s=1 and cnt==COUNT_MAX-1: go to S_HIGH, dout<=1, rise<=1, cnt<=0.
  - S_HIGH, S_WAIT_LO: mirror images of the above with s inverted; acceptance asserts fall.
- Net effect: dout flips at the edge where s has differed from dout for COUNT_MAX consecutive edges, counting that edge.
- Latency: dout changes at the (SYNC_STAGES+COUNT_MAX)th rising edge, counting the first edge that samples the new din value. rise/fall are high for exactly the cycle following that edge.
- rise and fall are never both high. Each is 0 in every cycle that is not an acceptance cycle.
- busy is 1 exactly in the S_WAIT_* states.
- Synchronous clear (clear_b=0 at an edge): state<=S_LOW, dout<=0, cnt<=0, rise<=0, fall<=0, busy<=0.
  - No fall pulse is produced even if dout was 1.
  - clear_b overrides any acceptance in the same edge.
  - After clear_b is released, if s=1 the FSM re-qualifies from S_LOW, taking COUNT_MAX edges.
- Reset mid-qualification aborts it; no pulse is emitted.
- The counter never exceeds COUNT_MAX-1 and never wraps.
- Input toggling every cycle never changes dout.

Test Plan:
- Reset: assert reset mid-clock with din=1 -> dout=rise=fall=busy=0 immediately (asynchronously) and held while reset=1; after release with din=1 and COUNT_MAX=4, SYNC_STAGES=2 -> dout=1 at the 6th edge, rise=1 for one cycle.
- Clean step: COUNT_MAX=4, SYNC_STAGES=2, din 0->1 before edge 0 -> busy=1 after edge 2; dout=1 and rise=1 after edge 5; rise=0 after edge 6. Then din 1->0 -> dout=0 and fall=1 six edges later.
- Bounce rejection: din pulses high for 3 cycles (less than COUNT_MAX=4), then low -> dout stays 0, no rise, busy returns to 0. Then din held high for 4+ cycles -> single rise, dout=1.
- Sync clear: dout=1 with din held high, then pulse clear_b=0 for one edge -> dout=0, fall stays 0. After release -> re-qualifies, rise=1 again COUNT_MAX edges later.
- Clear wins: clear_b=0 at the exact acceptance edge of S_WAIT_HI -> dout=0, rise=0, state S_LOW.
- Reset mid-wait: reset asserted while busy=1 with cnt=2 -> busy=0 and dout=0 at once. After release, with no din change, no rise/fall pulse ever appears.
